// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CMP_NONE,
        CMP_GT,
        CMP_LT,
        CMP_EQ
    } cmp_res_t;

endpackage

// File: rtl/cmp2_digit.sv
// Combinational 2-bit digit comparator producing one-hot gt/lt/eq flags.
module cmp2_digit
    import cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               gt,
    output logic               lt,
    output logic               eq
);

    cmp_res_t res;

    // Every x/y combination lands in exactly one branch, so the flags are one-hot.
    always_comb begin
        res = CMP_EQ;
        if (x > y)
            res = CMP_GT;
        else if (x < y)
            res = CMP_LT;
        gt = (res == CMP_GT);
        lt = (res == CMP_LT);
        eq = (res == CMP_EQ);
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// Sequential unsigned magnitude comparator, one 2-bit digit per clock, MSB first.
// Optional SMC_EARLY_EXIT_EN: finish on the first differing digit instead of constant time.
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int ND    = WIDTH / DIGIT_W;
    localparam int CNT_W = $clog2(ND) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ND - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CNT_W-1:0] cnt;
    logic             gt_q, lt_q, eq_q;

    logic d_gt, d_lt, d_eq;
    logic accept, run_step, run_exit;
    logic gt_nxt, lt_nxt, eq_nxt;

    cmp2_digit u_digit (
        .x  (a_sh[WIDTH-1 -: DIGIT_W]),
        .y  (b_sh[WIDTH-1 -: DIGIT_W]),
        .gt (d_gt),
        .lt (d_lt),
        .eq (d_eq)
    );

    always_comb begin
        accept   = (state_q == IDLE) && start;
        run_step = (state_q == RUN);
        // Sticky flags: the first decided digit wins over everything below it.
        gt_nxt   = gt_q | (d_gt & ~lt_q);
        lt_nxt   = lt_q | (d_lt & ~gt_q);
        eq_nxt   = ~gt_q & ~lt_q & d_eq;
`ifdef SMC_EARLY_EXIT_EN
        run_exit = (cnt == LAST) || d_gt || d_lt;
`else
        run_exit = (cnt == LAST);
`endif
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_exit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (run_step) begin
            a_sh <= a_sh << DIGIT_W;
            b_sh <= b_sh << DIGIT_W;
            cnt  <= cnt + CNT_W'(1);
            gt_q <= gt_nxt;
            lt_q <= lt_nxt;
            // eq only resolves once the walk ends with no digit having differed.
            if (run_exit)
                eq_q <= eq_nxt;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule
